xbar_loader: RTL
================

XBAR_LOADER -- requirements
Module: xbar_loader

Interface
REQ-001 SHALL have parameter W, default 8, width of the port-index fields.
REQ-002 SHALL have parameter IN, default 8, number of crossbar inputs; IN <= 2^(W-1).
REQ-003 SHALL have parameter OUT, default 8, number of crossbar outputs; OUT <= 2^W.
REQ-004 SHALL have port: clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: cmd_valid  input  1  command present.
REQ-007 SHALL have port: cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have port: cmd_op  input  2  0 NOP, 1 CONNECT, 2 DISCONNECT, 3 CLEAR_ALL.
REQ-009 SHALL have port: cmd_src  input  W  input index (CONNECT only).
REQ-010 SHALL have port: cmd_dst  input  W  output index (CONNECT, DISCONNECT).
REQ-011 SHALL have port: from  output  W  signed source select to crossbar; negative value means clear column.
REQ-012 SHALL have port: to  output  W  destination column to crossbar.
REQ-013 SHALL have port: put  output  1  single-cycle write strobe to crossbar.
REQ-014 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port: err  output  1  single-cycle pulse on a rejected command.

Function
REQ-016 SHALL implement states IDLE, ISSUE, CLEAR; cmd_ready = (state == IDLE) and reset deasserted.
REQ-017 SHALL accept a command on a rising edge with cmd_valid and cmd_ready both high.
REQ-018 SHALL, on accepted CONNECT with cmd_src < IN and cmd_dst < OUT: register from=cmd_src, to=cmd_dst, put=1, move to ISSUE.
REQ-019 SHALL, on accepted DISCONNECT with cmd_dst < OUT: register from=all-ones (-1), to=cmd_dst, put=1, move to ISSUE.
REQ-020 SHALL drive put for exactly one cycle, the cycle after acceptance; ISSUE returns to IDLE next edge (throughput one command per 2 cycles).
REQ-021 SHALL, on accepted CLEAR_ALL: move to CLEAR, column counter = 0; each CLEAR cycle drive put=1, from=-1, to=counter.
REQ-022 SHALL increment counter each CLEAR cycle; after to = OUT-1 is issued, return to IDLE (exactly OUT put pulses).
REQ-023 SHALL treat out-of-range index (CONNECT src >= IN or dst >= OUT; DISCONNECT dst >= OUT) as rejected: accepted, no put, err=1 the next cycle, stay IDLE.
REQ-024 SHALL treat NOP as accepted, no put, no err, stay IDLE.
REQ-025 SHALL hold from and to at last driven values when put is low; put low in IDLE except as in REQ-020.
REQ-026 SHALL ignore cmd_* while busy; a valid command is held by the sender until cmd_ready.
REQ-027 SHALL compare indices unsigned at width W; no wrap of counter past OUT-1.

Reset
REQ-028 SHALL, while reset is low, force put=0, err=0, from=0, to=0, counter=0, cmd_ready=0, independent of clock.
REQ-029 SHALL leave reset in IDLE (macro absent) or CLEAR (macro present); reset low mid-CLEAR or mid-ISSUE aborts immediately with no further put.

Configuration
REQ-030 SHALL honour macro XBAR_LOADER_BOOT_CLEAR_EN: defined -> reset state is CLEAR, busy=1 and OUT clear puts issue automatically from the first edge after reset release, then IDLE; undefined -> reset state is IDLE, busy=0, no puts until a command.

Verification (W=8, IN=8, OUT=8)
REQ-031 SHALL check: CONNECT src=3 dst=5 -> next cycle put=1, from=3, to=5; following cycle put=0, cmd_ready=1.
REQ-032 SHALL check: DISCONNECT dst=2 -> one put with from=8'hFF, to=2.
REQ-033 SHALL check: CLEAR_ALL -> puts with to=0..7 on 8 consecutive cycles, from=8'hFF, busy=1 throughout, then cmd_ready=1.
REQ-034 SHALL check: CONNECT src=9 dst=1 and DISCONNECT dst=8 -> no put, err pulses 1 cycle each.
REQ-035 SHALL check: reset low at CLEAR column 4 -> put=0 at once; after release, with XBAR_LOADER_BOOT_CLEAR_EN 8 puts to=0..7, without it none.
REQ-036 SHALL check: cmd_valid held through CLEAR_ALL with CONNECT 1->6 queued -> accepted only after last clear put, single put from=1, to=6.

Source files
------------

// File: rtl/xbar_loader.sv
// Crossbar configuration loader: turns connect/disconnect/clear commands into put strobes.
// Optional XBAR_LOADER_BOOT_CLEAR_EN: clear every column automatically after reset.
module xbar_loader #(
  parameter int W   = 8,
  parameter int IN  = 8,
  parameter int OUT = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_src,
  input  logic [W-1:0] cmd_dst,
  output logic [W-1:0] from,
  output logic [W-1:0] to,
  output logic         put,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CLEAR
  } state_e;

`ifdef XBAR_LOADER_BOOT_CLEAR_EN
  localparam state_e RST_STATE = S_CLEAR;
`else
  localparam state_e RST_STATE = S_IDLE;
`endif

  localparam logic [W:0]   IN_L  = (W+1)'(IN);
  localparam logic [W:0]   OUT_L = (W+1)'(OUT);
  localparam logic [W-1:0] LAST  = W'(OUT - 1);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] from_q, from_d;
  logic [W-1:0] to_q, to_d;
  logic         put_q, put_d;
  logic         err_q, err_d;

  logic accept;
  logic src_ok;
  logic dst_ok;
  logic op_nop;
  logic op_conn;
  logic op_disc;
  logic op_clr;

  assign cmd_ready = (state_q == S_IDLE) && reset;
  assign busy      = (state_q != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign src_ok    = {1'b0, cmd_src} < IN_L;
  assign dst_ok    = {1'b0, cmd_dst} < OUT_L;
  assign op_nop    = (cmd_op == 2'd0);
  assign op_conn   = (cmd_op == 2'd1);
  assign op_disc   = (cmd_op == 2'd2);
  assign op_clr    = (cmd_op == 2'd3);

  assign from = from_q;
  assign to   = to_q;
  assign put  = put_q;
  assign err  = err_q;

  // Next state, column counter and registered crossbar write fields.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    from_d  = from_q;
    to_d    = to_q;
    put_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            op_conn: begin
              if (src_ok && dst_ok) begin
                from_d  = cmd_src;
                to_d    = cmd_dst;
                put_d   = 1'b1;
                state_d = S_ISSUE;
              end else begin
                err_d = 1'b1;
              end
            end
            op_disc: begin
              if (dst_ok) begin
                from_d  = '1;
                to_d    = cmd_dst;
                put_d   = 1'b1;
                state_d = S_ISSUE;
              end else begin
                err_d = 1'b1;
              end
            end
            op_clr: begin
              cnt_d   = '0;
              from_d  = '1;
              to_d    = '0;
              put_d   = 1'b1;
              state_d = S_CLEAR;
            end
            op_nop: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end
      S_ISSUE: begin
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (!put_q) begin
          cnt_d  = '0;
          from_d = '1;
          to_d   = '0;
          put_d  = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d  = cnt_q + W'(1);
          from_d = '1;
          to_d   = cnt_q + W'(1);
          put_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any issue in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      from_q  <= '0;
      to_q    <= '0;
      put_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      from_q  <= from_d;
      to_q    <= to_d;
      put_q   <= put_d;
      err_q   <= err_d;
    end
  end

endmodule
